score_hex_display: RTL and testbench

- Downstream consumer of the game FSM's score and game_state. Drives the four HEX digits that the top level currently ties off.
- Converts the binary score into decimal using a sequential shift-and-add-3 (double-dabble) engine that runs once per game tick.
- Applies leading-zero blanking, and blinks the display in GAME_OVER.

---
 rtl/score_hex_display.sv | 134 +++++++++++++
 tb/tb_score_hex_display.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/score_hex_display.sv
// Score readout: serial double-dabble conversion per game tick, then a
// seven-segment decode with leading-zero blanking and GAME_OVER blink.
module score_hex_display #(
  parameter int BLINK_TICKS = 30,
  parameter bit LZ_BLANK    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        game_tick,
  input  logic [15:0] score,
  input  logic [2:0]  game_state,
  output logic        busy,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3
);

  typedef enum logic [1:0] {IDLE, CONVERT, LATCH} state_t;

  localparam logic [15:0] SCORE_MAX  = 16'd9999;
  localparam logic [7:0]  BLINK_LAST = 8'(BLINK_TICKS - 1);
  localparam logic [2:0]  GAME_OVER  = 3'd1;

  state_t state, state_nxt;

  logic [15:0]      bin;
  logic [15:0]      bcd;
  logic [15:0]      bcd_adj;
  logic [31:0]      shifted;
  logic [3:0]       bit_cnt;
  logic [3:0][3:0]  digit;
  logic [7:0]       blink_cnt;
  logic             blank_phase;
  logic [3:0]       lz_off;
  logic [3:0][6:0]  hex;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (game_tick) state_nxt = CONVERT;
      CONVERT: if (bit_cnt == 4'd15) state_nxt = LATCH;
      LATCH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // add-3 correction on every nibble before the shift
  for (genvar n = 0; n < 4; n++) begin : g_adj
    assign bcd_adj[n*4 +: 4] = (bcd[n*4 +: 4] >= 4'd5) ? bcd[n*4 +: 4] + 4'd3
                                                       : bcd[n*4 +: 4];
  end

  assign shifted = {bcd_adj, bin} << 1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bin     <= '0;
      bcd     <= '0;
      bit_cnt <= '0;
      digit   <= '0;
    end else begin
      case (state)
        IDLE: if (game_tick) begin
          bin     <= (score > SCORE_MAX) ? SCORE_MAX : score;
          bcd     <= '0;
          bit_cnt <= '0;
        end
        CONVERT: begin
          {bcd, bin} <= shifted;
          bit_cnt    <= bit_cnt + 4'd1;
        end
        LATCH:   digit <= bcd;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt   <= '0;
      blank_phase <= 1'b0;
    end else if (game_state != GAME_OVER) begin
      blink_cnt   <= '0;
      blank_phase <= 1'b0;
    end else if (game_tick) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blank_phase <= ~blank_phase;
      end else begin
        blink_cnt <= blink_cnt + 8'd1;
      end
    end
  end

  // a digit is blanked only when it and every more significant digit are zero
  assign lz_off[3] = LZ_BLANK && (digit[3] == 4'd0);
  assign lz_off[2] = lz_off[3] && (digit[2] == 4'd0);
  assign lz_off[1] = lz_off[2] && (digit[1] == 4'd0);
  assign lz_off[0] = 1'b0;

  for (genvar n = 0; n < 4; n++) begin : g_seg
    assign hex[n] = (blank_phase || lz_off[n]) ? 7'h7F : seg7(digit[n]);
  end

  assign HEX0 = hex[0];
  assign HEX1 = hex[1];
  assign HEX2 = hex[2];
  assign HEX3 = hex[3];

endmodule

// File: tb/tb_score_hex_display.sv
// Random + directed bench for score_hex_display: two instances (blanking on and
// off, different blink periods) share stimulus; a monitor scores results.
module tb_score_hex_display;

  logic        clk = 0;
  logic        rst = 1;
  logic        game_tick = 0;
  logic [15:0] score = '0;
  logic [2:0]  game_state = '0;
  logic        busy_a, busy_b;
  logic [6:0]  a0, a1, a2, a3, b0, b1, b2, b3;

  score_hex_display #(.BLINK_TICKS(2), .LZ_BLANK(1)) dut_a (
    .clk(clk), .rst(rst), .game_tick(game_tick), .score(score),
    .game_state(game_state), .busy(busy_a),
    .HEX0(a0), .HEX1(a1), .HEX2(a2), .HEX3(a3));

  score_hex_display #(.BLINK_TICKS(3), .LZ_BLANK(0)) dut_b (
    .clk(clk), .rst(rst), .game_tick(game_tick), .score(score),
    .game_state(game_state), .busy(busy_b),
    .HEX0(b0), .HEX1(b1), .HEX2(b2), .HEX3(b3));

  always #5 clk = ~clk;

  typedef struct { int val; int issue; } conv_t;
  typedef struct { int due; logic [27:0] ha; logic [27:0] hb; logic bsy; } spot_t;

  conv_t sb[$];
  spot_t spots[$];
  int    cyc = 0;
  int    checks = 0, passed = 0;
  bit    done = 0;
  int    go_ticks = 0;
  int    busy_end = 0, last_val = 0, prev_val = 0;
  logic  prev_busy = 0;
  logic  [27:0] ha, hb;
  conv_t c;
  spot_t sp;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: seg = 7'h40;  1: seg = 7'h79;  2: seg = 7'h24;  3: seg = 7'h30;
      4: seg = 7'h19;  5: seg = 7'h12;  6: seg = 7'h02;  7: seg = 7'h78;
      8: seg = 7'h00;  9: seg = 7'h10;  default: seg = 7'h7F;
    endcase
  endfunction

  // {HEX3,HEX2,HEX1,HEX0} for a decimal value
  function automatic logic [27:0] hex_of(input int v, input bit lz, input bit blank);
    logic [27:0] r;
    int p;
    p = 1;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      if (blank || (lz && i > 0 && v < p)) r[i*7 +: 7] = 7'h7F;
      else                                 r[i*7 +: 7] = seg((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic int sat(input int s);
    return (s > 9999) ? 9999 : s;
  endfunction

  // blink reference: number of ticks seen since GAME_OVER was entered
  always @(posedge clk or negedge rst) begin
    if (!rst)                    go_ticks <= 0;
    else if (game_state == 3'd1) begin
      if (game_tick) go_ticks <= go_ticks + 1;
    end else                     go_ticks <= 0;
  end

  wire phase_a = ((go_ticks / 2) % 2) == 1;
  wire phase_b = ((go_ticks / 3) % 2) == 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    ha = {a3, a2, a1, a0};
    hb = {b3, b2, b1, b0};
    while (spots.size() > 0 && spots[0].due <= cyc) begin
      sp = spots.pop_front();
      chk("spot_on_time", sp.due, cyc);
      chk("spot_hex_a", ha, sp.ha);
      chk("spot_hex_b", hb, sp.hb);
      chk("spot_busy", busy_a, sp.bsy);
    end
    if (rst && prev_busy && !busy_a) begin
      chk("conv_expected", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        c = sb.pop_front();
        chk("latency", cyc - c.issue, 18);
        chk("conv_hex_a", ha, hex_of(c.val, 1, phase_a));
        chk("conv_hex_b", hb, hex_of(c.val, 0, phase_b));
      end
    end
    prev_busy = busy_a;
    if (done || cyc > 60000) begin
      chk("finished_in_time", done, 1);
      chk("sb_drained", sb.size(), 0);
      chk("spots_drained", spots.size(), 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
    end
  end

  // one clock edge of stimulus; a tick is accepted only when the FSM is idle
  task automatic drive(input bit t, input int s, input logic [2:0] g);
    game_tick  = t;
    score      = 16'(s);
    game_state = g;
    if (t && rst && cyc + 1 > busy_end) begin
      sb.push_back('{sat(s), cyc});
      prev_val = last_val;
      last_val = sat(s);
      busy_end = cyc + 18;
    end
    @(posedge clk); #1;
    game_tick = 0;
  endtask

  task automatic wait_idle();
    while (cyc <= busy_end + 1) drive(0, int'(score), game_state);
  endtask

  function automatic int rnd_score();
    case ($urandom_range(0, 3))
      0:       return int'($urandom_range(0, 99));
      1:       return int'($urandom_range(0, 9999));
      2:       return int'($urandom_range(10000, 65535));
      default: return int'($urandom_range(0, 999));
    endcase
  endfunction

  initial begin
    int cur_s;
    logic [2:0] cur_g;
    #2 rst = 0;
    @(posedge clk); #1;
    spots.push_back('{cyc, hex_of(0, 1, 0), hex_of(0, 0, 0), 1'b0});
    drive(0, 0, 0);
    drive(0, 0, 0);
    rst = 1;
    drive(1, 0, 0);
    wait_idle();

    // 1234, with the old value still showing on the last CONVERT edge
    drive(1, 1234, 0);
    spots.push_back('{cyc + 16, hex_of(prev_val, 1, 0), hex_of(prev_val, 0, 0), 1'b1});
    wait_idle();

    drive(1, 50000, 0); wait_idle();
    drive(1, 7, 0);     wait_idle();

    // tick on E5 ignored, score change on E3 ignored
    drive(1, 1234, 0);
    drive(0, 1234, 0); drive(0, 1234, 0);
    drive(0, 42, 0);   drive(0, 42, 0);
    drive(1, 42, 0);
    wait_idle();

    // blink in GAME_OVER, then WIN holds steady
    for (int i = 0; i < 6; i++) begin
      drive(1, 12, 1);
      repeat (20) drive(0, 12, 1);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, 12, 2);
      repeat (20) drive(0, 12, 2);
    end

    // reset on E8 of a conversion
    drive(1, 5555, 0);
    repeat (8) drive(0, 5555, 0);
    rst = 0;
    sb.delete();
    busy_end = 0; last_val = 0; prev_val = 0;
    spots.push_back('{cyc, hex_of(0, 1, 0), hex_of(0, 0, 0), 1'b0});
    drive(0, 5555, 0);
    drive(0, 5555, 0);
    rst = 1;
    drive(0, 4321, 0);
    drive(1, 4321, 0);
    wait_idle();

    cur_s = 0;
    cur_g = 3'd0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0)   cur_s = rnd_score();
      if ($urandom_range(0, 199) == 0) cur_g = 3'($urandom_range(0, 7));
      drive($urandom_range(0, 11) == 0, cur_s, cur_g);
    end
    wait_idle();
    done = 1;
  end

endmodule
